dsp_mac_ctrl: RTL and testbench

//  Upstream sequencer for the DSP48A1 slice model (DSP_2). Accepts a valid/ready stream of
//  18-bit (A,B) operand pairs and drives the slice to compute dot products of VEC_LEN terms.
//  The slice is steered through OPMODE: the first term loads P=A*B, later terms accumulate
//  P=P+A*B. The block then waits out the slice pipeline, captures DSP_P and presents it on a

---
 rtl/dsp_mac_ctrl.sv | 118 +++++++++++
 tb/tb_dsp_mac_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_ctrl.sv
// Sequencer feeding (A,B) pairs to a DSP48A1 slice; accumulates VEC_LEN products per result.
// Latency: result valid PIPE_LAT+1 edges after the last term is accepted.
// Backpressure: in_ready low outside ACCUM; the result is held until res_ready.
module dsp_mac_ctrl #(
  parameter int VEC_LEN  = 8,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [47:0]      dsp_c,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  localparam logic [7:0] OPM_LOAD = 8'b0000_0001;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC  = 8'b0000_1001;  // X=M, Z=P

  state_t           state, state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic             accept, last_term, drain_done, res_take;

  assign accept     = in_valid && in_ready;
  assign last_term  = (term_cnt == CNT_W'(VEC_LEN - 1));
  assign drain_done = (drain_cnt == CNT_W'(PIPE_LAT));
  assign res_take   = res_valid && res_ready;

  assign dsp_d = '0;
  assign dsp_c = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last_term) state_nxt = DRAIN;
        DRAIN:   if (drain_done)          state_nxt = HOLD;
        HOLD:    if (res_take)            state_nxt = ACCUM;
        default:                          state_nxt = ACCUM;
      endcase
    end
  end

  // An aborting cycle refuses pairs so no handshake is silently dropped.
  always_comb begin
    in_ready = (state == ACCUM) && dsp_ce && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= 8'h00;
      dsp_ce     <= 1'b0;
      dsp_rst    <= 1'b1;
      term_cnt   <= '0;
      drain_cnt  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      dsp_ce  <= 1'b1;
      dsp_rst <= abort;
      if (abort) begin
        dsp_a      <= '0;
        dsp_b      <= '0;
        dsp_opmode <= 8'h00;
        term_cnt   <= '0;
        drain_cnt  <= '0;
        res_valid  <= 1'b0;
      end else begin
        if (accept) begin
          dsp_a      <= in_a;
          dsp_b      <= in_b;
          dsp_opmode <= (term_cnt == '0) ? OPM_LOAD : OPM_ACC;
          term_cnt   <= last_term ? '0 : term_cnt + 1'b1;
        end else begin
          // Zero operands with accumulate keep P unchanged through bubbles.
          dsp_a      <= '0;
          dsp_b      <= '0;
          dsp_opmode <= OPM_ACC;
        end
        if (state == DRAIN) begin
          if (drain_done) begin
            res_data  <= dsp_p;
            res_valid <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        if (state == HOLD && res_take) res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl with a behavioural DSP48A1 slice (A1REG/B1REG/OPMODEREG, MREG, PREG).
// Expected dot products are queued as vectors are sent and popped on each result handshake.
module tb_dsp_mac_ctrl;

  localparam int VEC_LEN  = 4;
  localparam int PIPE_LAT = 3;
  localparam int CNT_W    = 8;

  logic             clk, rst_n, abort, in_valid, in_ready, res_ready, res_valid;
  logic [17:0]      in_a, in_b, dsp_a, dsp_b, dsp_d;
  logic [47:0]      dsp_c, dsp_p, res_data;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce, dsp_rst;
  logic [CNT_W-1:0] term_cnt;

  dsp_mac_ctrl #(.VEC_LEN(VEC_LEN), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
    .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .term_cnt(term_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slice model: one input/opmode register stage, MREG, PREG, sync reset, common CE.
  logic signed [17:0] s_a1, s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_opm;
  logic [47:0]        s_p, s_x, s_z;

  always_comb begin
    s_x = '0;
    s_z = '0;
    if (s_opm[1:0] == 2'b01) s_x = {{12{s_m[35]}}, s_m};
    if (s_opm[3:2] == 2'b10) s_z = s_p;
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1 <= '0; s_b1 <= '0; s_opm <= '0; s_m <= '0; s_p <= '0;
    end else if (dsp_ce) begin
      s_a1  <= dsp_a;
      s_b1  <= dsp_b;
      s_opm <= dsp_opmode;
      s_m   <= s_a1 * s_b1;
      s_p   <= s_x + s_z;
    end
  end
  assign dsp_p = s_p;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises = 0;
  logic rv_q = 1'b0;
  logic [47:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Samples a little after the falling edge, once the driver has settled its inputs.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && res_valid && !rv_q) rises++;
    if (rst_n && res_valid && res_ready) begin
      chk("sb_has_exp", 48'(sb.size() > 0), 48'd1);
      if (sb.size() > 0) chk("res_data", res_data, sb.pop_front());
    end
    rv_q = rst_n && res_valid;
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 48'(in_ready), 48'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("res_wait", 48'(res_valid), 48'd1);
  endtask

  task automatic send_vec(input logic [17:0] a[VEC_LEN], input logic [17:0] b[VEC_LEN], input bit push);
    logic [47:0] acc = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      acc = acc + 48'(a[i]) * 48'(b[i]);
      send(a[i], b[i]);
    end
    if (push) sb.push_back(acc);
  endtask

  initial begin
    int n;
    int r0;
    logic [17:0] va[VEC_LEN];
    logic [17:0] vb[VEC_LEN];
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 48'(in_ready), 48'd0);
    chk("rst_res_valid", 48'(res_valid), 48'd0);
    chk("rst_res_data", res_data, 48'd0);
    chk("rst_term_cnt", 48'(term_cnt), 48'd0);
    chk("rst_dsp_ab", 48'({dsp_a, dsp_b}), 48'd0);
    chk("rst_opmode", 48'(dsp_opmode), 48'd0);
    chk("rst_dsp_ce", 48'(dsp_ce), 48'd0);
    chk("rst_dsp_rst", 48'(dsp_rst), 48'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 48'(in_ready), 48'd1);
    chk("rel_dsp_rst", 48'(dsp_rst), 48'd0);
    chk("rel_dsp_ce", 48'(dsp_ce), 48'd1);
    chk("dsp_dc_zero", {dsp_c[29:0], dsp_d}, 48'd0);

    // Back-to-back 1..4 x 2 = 20, result one cycle wide
    send(18'd1, 18'd2);
    chk("t2_opm_first", 48'(dsp_opmode), 48'h01);
    chk("t2_dsp_a", 48'(dsp_a), 48'd1);
    chk("t2_term_cnt", 48'(term_cnt), 48'd1);
    send(18'd2, 18'd2);
    chk("t2_opm_acc", 48'(dsp_opmode), 48'h09);
    send(18'd3, 18'd2);
    send(18'd4, 18'd2);
    sb.push_back(48'd20);
    chk("t2_term_wrap", 48'(term_cnt), 48'd0);
    chk("t2_drain_ready", 48'(in_ready), 48'd0);
    wait_res(n);
    chk("t2_latency", 48'(n), 48'(PIPE_LAT + 1));
    @(negedge clk);
    chk("t2_pulse_1cyc", 48'(res_valid), 48'd0);

    // Gap of 3 idle cycles between terms 2 and 3
    send(18'd1, 18'd2);
    send(18'd2, 18'd2);
    repeat (3) @(negedge clk);
    send(18'd3, 18'd2);
    send(18'd4, 18'd2);
    sb.push_back(48'd20);
    wait_res(n);
    @(negedge clk);

    // Held result under backpressure, then a second vector
    res_ready = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 18'd10; vb[i] = 18'd5; end
    send_vec(va, vb, 1'b1);
    wait_res(n);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 48'(res_valid), 48'd1);
      chk("t4_hold_data", res_data, 48'd200);
      chk("t4_hold_ready", 48'(in_ready), 48'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 18'd1; vb[i] = 18'd1; end
    send_vec(va, vb, 1'b1);
    wait_res(n);
    @(negedge clk);

    // Abort after two terms of 7*7
    send(18'd7, 18'd7);
    send(18'd7, 18'd7);
    chk("t5_term_cnt", 48'(term_cnt), 48'd2);
    abort = 1'b1;
    #1;
    chk("t5_abort_ready", 48'(in_ready), 48'd0);
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_cnt", 48'(term_cnt), 48'd0);
    chk("t5_abort_rst", 48'(dsp_rst), 48'd1);
    chk("t5_abort_opm", 48'(dsp_opmode), 48'd0);
    @(negedge clk);
    chk("t5_rst_1cyc", 48'(dsp_rst), 48'd0);
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 18'(i + 1); vb[i] = 18'd1; end
    send_vec(va, vb, 1'b1);
    wait_res(n);
    @(negedge clk);

    // Reset pulse during drain discards the vector
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 18'd3; vb[i] = 18'd3; end
    send_vec(va, vb, 1'b0);
    @(negedge clk);
    r0 = rises;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 48'(res_valid), 48'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_no_rise", 48'(rises - r0), 48'd0);
    for (int i = 0; i < VEC_LEN; i++) begin va[i] = 18'd2; vb[i] = 18'd5; end
    send_vec(va, vb, 1'b1);
    wait_res(n);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", 48'(sb.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
